serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial, multi-cycle subtractor: computes diff = x - y - bin, one bit per clock, LSB first, with a borrow flip-flop.
- Sequential counterpart to the 4-bit ripple-carry adder: the inverse operation on the same operand format (x, y, carry/borrow in, result, carry/borrow out).
- Trades WIDTH cycles of latency for a single 1-bit subtractor cell.
- Start/busy/done handshake toward the controlling logic.

Parameters:
- WIDTH, 4, operand and result width in bits (>= 2).
- CNT_W, $clog2(WIDTH)+1, bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- x  input  WIDTH  minuend, unsigned; sampled with accepted start.
- y  input  WIDTH  subtrahend, unsigned; sampled with accepted start.
- bin  input  1  borrow-in; sampled with accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; diff and bout are valid.
- diff  output  WIDTH  result (x - y - bin) mod 2^WIDTH.
- bout  output  1  borrow-out: 1 when x < y + bin (unsigned).

Behaviour:
- Clock and reset: one clock domain (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, busy=0, done=0, diff=0, bout=0, counter=0, borrow=0, shift registers=0.
- States:
  - IDLE: busy=0, done=0. start=1 -> load x, y into shift registers; borrow<=bin; counter<=0; go to SHIFT.
  - SHIFT: busy=1. Each edge: d = xs[0]^ys[0]^borrow; borrow <= (~xs[0]&ys[0]) | (~(xs[0]^ys[0])&borrow); d shifts into result MSB; xs and ys shift right; counter++. When counter==WIDTH-1 on this edge, go to DONE.
  - DONE: busy=0, done=1 for exactly one cycle; diff <= result register; bout <= final borrow. start=1 here is accepted exactly as in IDLE (back-to-back operation). Otherwise go to IDLE.
- Latency: start accepted at edge E0. Bits are processed at edges E1..E_WIDTH. done is high in the cycle following E_WIDTH.
- Throughput: one operation per WIDTH+1 cycles.
- diff and bout hold their last value until the next DONE. They do not change during SHIFT.
- start while busy=1 is ignored. Operand inputs may change freely after acceptance.
- Boundaries:
  - x=y, bin=0 -> diff=0, bout=0.
  - x=0, y=0, bin=1 -> wrap to all-ones, bout=1.
  - x=2^WIDTH-1, y=0 -> no borrow.
- Reset asserted mid-SHIFT aborts immediately. No done pulse follows. All outputs return to reset values.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVF_EN.
- Defined: adds output port ovf (1 bit, reset 0), the two's-complement signed-overflow flag. ovf = (x[MSB] != y[MSB]) & (diff[MSB] != x[MSB]), evaluated on the MSB step and registered alongside bout. bin is folded in via the final borrow, i.e. overflow = borrow into MSB XOR borrow out of MSB.
- Undefined: port and logic absent. Remaining behaviour is identical.

Decomposition:
- Shared package serial_arith_pkg: state enum (IDLE, SHIFT, DONE), 2-bit encoding.
- One sub-module, full_subtractor: combinational 1-bit cell (a, b, bin -> d, bout), reused by the top.

Test Plan:
- Reset, then x=4, y=1, bin=0, start pulse -> busy high for 4 cycles; done one cycle later; diff=3, bout=0.
- x=10, y=15, bin=0 -> diff=11, bout=1. With OVF_EN: ovf=0.
- x=3, y=5, bin=1 -> diff=13, bout=1. Then hold start=1 through the DONE cycle with x=0, y=0, bin=1 -> second op accepted back-to-back; diff=15, bout=1; no idle cycle between.
- With OVF_EN:
  - x=8, y=1, bin=0 -> diff=7, bout=0, ovf=1.
  - x=7, y=15, bin=0 -> diff=8, bout=1, ovf=1.
- Pulse start mid-SHIFT with different operands -> ignored; result matches the first operands.
- Assert rst_n=0 two cycles into SHIFT -> busy, done, diff, bout all 0 immediately; no done pulse after release.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: controller state encoding.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Combinational 1-bit subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first: diff = x - y - bin over WIDTH cycles, start/busy/done handshake.
// Optional signed-overflow flag output ovf when SERIAL_SUBTRACTOR_OVF_EN is defined.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state_r, state_nx_s;
  logic [WIDTH-1:0]   xs_r, ys_r;
  logic [WIDTH-2:0]   res_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               borrow_r;
  logic               busy_r, done_r, bout_r;
  logic [WIDTH-1:0]   diff_r;
  logic               load_s, shift_s, last_s;
  logic               d_s, bo_s;
  logic [WIDTH-1:0]   res_cat_s;

  full_subtractor u_cell (
    .a    (xs_r[0]),
    .b    (ys_r[0]),
    .bin  (borrow_r),
    .d    (d_s),
    .bout (bo_s)
  );

  // New bit enters at the MSB; on the last step this is the complete result.
  assign res_cat_s = {d_s, res_r};

  // Next-state and datapath control decode.
  always_comb begin
    state_nx_s = state_r;
    load_s     = 1'b0;
    shift_s    = 1'b0;
    last_s     = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          load_s     = 1'b1;
          state_nx_s = SHIFT;
        end else begin
          state_nx_s = IDLE;
        end
      end
      SHIFT: begin
        shift_s = 1'b1;
        if (cnt_r == LAST_CNT) begin
          last_s     = 1'b1;
          state_nx_s = DONE;
        end else begin
          state_nx_s = SHIFT;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Operand shift registers, bit counter, borrow flip-flop and partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xs_r     <= '0;
      ys_r     <= '0;
      res_r    <= '0;
      cnt_r    <= '0;
      borrow_r <= 1'b0;
    end else if (load_s) begin
      xs_r     <= x;
      ys_r     <= y;
      res_r    <= '0;
      cnt_r    <= '0;
      borrow_r <= bin;
    end else if (shift_s) begin
      xs_r     <= {1'b0, xs_r[WIDTH-1:1]};
      ys_r     <= {1'b0, ys_r[WIDTH-1:1]};
      res_r    <= res_cat_s[WIDTH-1:1];
      cnt_r    <= cnt_r + CNT_W'(1);
      borrow_r <= bo_s;
    end
  end

  // Registered handshake and result outputs; results only move on the final step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      diff_r <= '0;
      bout_r <= 1'b0;
    end else begin
      busy_r <= (state_nx_s == SHIFT);
      done_r <= last_s;
      if (last_s) begin
        diff_r <= res_cat_s;
        bout_r <= bo_s;
      end
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign diff = diff_r;
  assign bout = bout_r;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic ovf_r;

  // Signed overflow: borrow into the MSB differs from borrow out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (last_s) begin
      ovf_r <= borrow_r ^ bo_s;
    end
  end

  assign ovf = ovf_r;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=4), with ovf checks when SERIAL_SUBTRACTOR_OVF_EN is defined.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] x, y;
  logic       bin;
  logic       busy, done, bout;
  logic [3:0] diff;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic       ovf;
`endif

  int n_checks;
  int n_fails;

  serial_subtractor #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .x     (x),
    .y     (y),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present operands with start for one edge; returns just after the accepting edge.
  task automatic start_op(input logic [3:0] xa, input logic [3:0] ya, input logic ba);
    @(negedge clk);
    x = xa; y = ya; bin = ba; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Bounded wait for done, then check latency, results and the optional overflow flag.
  task automatic wait_done(input string tag, input int exp_lat, input logic [3:0] exp_d,
                           input logic exp_b, input logic exp_o);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_diff"}, diff, exp_d);
    chk({tag, "_bout"}, bout, exp_b);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    chk({tag, "_ovf"}, ovf, exp_o);
`else
    if (exp_o === 1'bx) $display("note: no expectation");
`endif
  endtask

  initial begin
    int dcount;
    n_checks = 0;
    n_fails  = 0;
    rst_n = 1'b0; start = 1'b0; x = 4'd0; y = 4'd0; bin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_diff", diff, 4'd0);
    chk("rst_bout", bout, 1'b0);
    rst_n = 1'b1;

    // 4 - 1: busy for four cycles, done on the fifth
    start_op(4'd4, 4'd1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("busy_window", busy, 1'b1);
      chk("no_early_done", done, 1'b0);
      @(negedge clk);
    end
    wait_done("op_4m1", 0, 4'd3, 1'b0, 1'b0);
    @(negedge clk);
    chk("done_pulse_width", done, 1'b0);

    start_op(4'd10, 4'd15, 1'b0);
    wait_done("op_10m15", 4, 4'd11, 1'b1, 1'b0);

    // back-to-back: start held through the DONE cycle
    start_op(4'd3, 4'd5, 1'b1);
    wait_done("op_3m5m1", 4, 4'd13, 1'b1, 1'b0);
    x = 4'd0; y = 4'd0; bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", busy, 1'b1);
    wait_done("op_0m0m1", 4, 4'd15, 1'b1, 1'b0);

    start_op(4'd8, 4'd1, 1'b0);
    wait_done("op_8m1", 4, 4'd7, 1'b0, 1'b1);
    start_op(4'd7, 4'd15, 1'b0);
    wait_done("op_7m15", 4, 4'd8, 1'b1, 1'b1);
    start_op(4'd6, 4'd6, 1'b0);
    wait_done("op_eq", 4, 4'd0, 1'b0, 1'b0);
    start_op(4'd15, 4'd0, 1'b0);
    wait_done("op_15m0", 4, 4'd15, 1'b0, 1'b0);

    // start pulsed mid-SHIFT is ignored; diff holds its old value meanwhile
    start_op(4'd6, 4'd2, 1'b0);
    @(negedge clk);
    x = 4'd1; y = 4'd14; bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("hold_diff", diff, 4'd15);
    chk("hold_bout", bout, 1'b0);
    wait_done("op_ignore", 2, 4'd4, 1'b0, 1'b0);

    // reset two cycles into SHIFT aborts immediately
    start_op(4'd5, 4'd3, 1'b0);
    @(negedge clk);
    chk("pre_abort_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_diff", diff, 4'd0);
    chk("abort_bout", bout, 1'b0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    chk("abort_ovf", ovf, 1'b0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dcount++;
    end
    chk("no_done_after_abort", dcount, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
